// File: rtl/ts_strict_mq.sv
// Strict-priority egress selector: locks onto the highest-index queue that is
// valid with an open gate and forwards that whole frame to the MAC stream.
module ts_strict_mq #(
   parameter int NUM_QUEUES = 8,
   parameter int DATA_WIDTH = 64,
   parameter int QID_WIDTH  = 3
) (
   input  logic                                axis_aclk,
   input  logic                                axis_reset,
   input  logic [NUM_QUEUES*DATA_WIDTH-1:0]    s_axis_tdata,
   input  logic [NUM_QUEUES*DATA_WIDTH/8-1:0]  s_axis_tkeep,
   input  logic [NUM_QUEUES-1:0]               s_axis_tlast,
   input  logic [NUM_QUEUES-1:0]               s_axis_tvalid,
   output logic [NUM_QUEUES-1:0]               s_axis_tready,
   input  logic [NUM_QUEUES-1:0]               gate_state,
   output logic [DATA_WIDTH-1:0]               m_axis_tdata,
   output logic [DATA_WIDTH/8-1:0]             m_axis_tkeep,
   output logic                                m_axis_tlast,
   output logic                                m_axis_tvalid,
   input  logic                                m_axis_tready,
   output logic [QID_WIDTH-1:0]                sel_qid,
   output logic                                sel_active,
   output logic [31:0]                         frame_count
);

   localparam int KEEP_W = DATA_WIDTH / 8;
   localparam int IW     = $clog2(NUM_QUEUES);

   typedef enum logic {IDLE, LOCKED} state_t;

   state_t                                 state;
   logic [NUM_QUEUES-1:0][DATA_WIDTH-1:0]  q_data;
   logic [NUM_QUEUES-1:0][KEEP_W-1:0]      q_keep;
   logic [NUM_QUEUES-1:0]                  eligible;
   logic [QID_WIDTH-1:0]                   winner;
   logic [IW-1:0]                          sel_idx;
   logic                                   locked;
   logic                                   xfer_last;

   assign q_data   = s_axis_tdata;
   assign q_keep   = s_axis_tkeep;
   assign eligible = s_axis_tvalid & gate_state;
   assign sel_idx  = sel_qid[IW-1:0];
   assign locked   = (state == LOCKED);

   // Ascending scan so the highest eligible index is the last one written.
   always_comb begin
      winner = '0;
      for (int i = 0; i < NUM_QUEUES; i++)
         if (eligible[i]) winner = QID_WIDTH'(i);
   end

   assign m_axis_tdata  = q_data[sel_idx];
   assign m_axis_tkeep  = q_keep[sel_idx];
   assign m_axis_tlast  = s_axis_tlast[sel_idx];
   assign m_axis_tvalid = locked & s_axis_tvalid[sel_idx];
   assign sel_active    = locked;
   assign xfer_last     = m_axis_tvalid & m_axis_tready & m_axis_tlast;

   for (genvar q = 0; q < NUM_QUEUES; q++) begin : g_rdy
      assign s_axis_tready[q] = locked && (sel_idx == IW'(q)) && m_axis_tready;
   end

   // Counter is rewritten every cycle, even when it only holds its value.
   always_ff @(posedge axis_aclk) begin
      if (!axis_reset) begin
         state       <= IDLE;
         sel_qid     <= '0;
         frame_count <= '0;
      end else begin
         frame_count <= frame_count + 32'(xfer_last);
         case (state)
            IDLE: begin
               if (|eligible) begin
                  sel_qid <= winner;
                  state   <= LOCKED;
               end
            end
            LOCKED: begin
               if (xfer_last) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ts_strict_mq.sv
// Bench for ts_strict_mq: per-queue frame queues feed the DUT and a frame-level
// model of who owns the output predicts every cycle's outputs.
module tb_ts_strict_mq;

   localparam int NQ = 8;
   localparam int DW = 64;
   localparam int KW = 8;
   localparam int QW = 3;

   typedef struct packed {logic [DW-1:0] d; logic [KW-1:0] k; logic l;} beat_t;
   typedef struct {int qid; int cyc; logic [DW-1:0] d;} xfer_t;

   logic             clk = 1'b0;
   logic             rstn;
   logic [NQ*DW-1:0] s_tdata;
   logic [NQ*KW-1:0] s_tkeep;
   logic [NQ-1:0]    s_tlast, s_tvalid, s_tready, gate;
   logic [DW-1:0]    m_tdata;
   logic [KW-1:0]    m_tkeep;
   logic             m_tlast, m_tvalid, mrdy, sel_active;
   logic [QW-1:0]    sel_qid;
   logic [31:0]      frame_count;

   beat_t            srcq[NQ][$];
   xfer_t            xlog[$];
   logic [NQ-1:0]    bubble;
   int               lock, last_sel, cyc, n_chk, n_fail;
   logic [31:0]      cnt;
   logic [NQ+QW+33:0] obs, expv;
   logic [DW+KW:0]   obs_d, exp_d;

   ts_strict_mq #(.NUM_QUEUES(NQ), .DATA_WIDTH(DW), .QID_WIDTH(QW)) dut (
      .axis_aclk(clk), .axis_reset(rstn),
      .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tlast(s_tlast),
      .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready), .gate_state(gate),
      .m_axis_tdata(m_tdata), .m_axis_tkeep(m_tkeep), .m_axis_tlast(m_tlast),
      .m_axis_tvalid(m_tvalid), .m_axis_tready(mrdy),
      .sel_qid(sel_qid), .sel_active(sel_active), .frame_count(frame_count)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, time %0t limit 500000", $time);
      $fatal(1);
   end

   task automatic drive();
      for (int i = 0; i < NQ; i++) begin
         if (srcq[i].size() > 0 && !bubble[i]) begin
            s_tvalid[i] = 1'b1;
            s_tdata[i*DW +: DW] = srcq[i][0].d;
            s_tkeep[i*KW +: KW] = srcq[i][0].k;
            s_tlast[i] = srcq[i][0].l;
         end else begin
            s_tvalid[i] = 1'b0;
            s_tdata[i*DW +: DW] = '0;
            s_tkeep[i*KW +: KW] = '0;
            s_tlast[i] = 1'b0;
         end
      end
   endtask

   task automatic load(input int q, input int n);
      beat_t b;
      for (int i = 0; i < n; i++) begin
         b.d = {$urandom, $urandom};
         b.l = (i == n - 1);
         b.k = b.l ? (8'($urandom) | 8'h01) : 8'hFF;
         srcq[q].push_back(b);
      end
   endtask

   function automatic logic exp_vld();
      return (lock >= 0) ? s_tvalid[lock] : 1'b0;
   endfunction

   function automatic logic [NQ-1:0] exp_rdy();
      return (lock >= 0 && mrdy) ? (NQ'(1) << lock) : '0;
   endfunction

   function automatic bit all_idle();
      bit e = (lock < 0);
      for (int i = 0; i < NQ; i++) if (srcq[i].size() != 0) e = 0;
      return e;
   endfunction

   // One clock: the model decides ownership from the frame-level rules, then
   // accepted beats leave their source queues and the inputs are re-driven.
   task automatic step();
      logic [NQ-1:0] hs, elig;
      int nl, nsel;
      logic [31:0] ncnt;
      xfer_t x;
      hs = exp_rdy() & s_tvalid;
      nl = lock; nsel = last_sel; ncnt = cnt;
      if (!rstn) begin
         nl = -1; nsel = 0; ncnt = 0;
      end else if (lock < 0) begin
         elig = s_tvalid & gate;
         for (int i = 0; i < NQ; i++) if (elig[i]) nl = i;
         if (nl >= 0) nsel = nl;
      end else if (hs[lock] && srcq[lock][0].l) begin
         nl = -1; ncnt = cnt + 1;
      end
      @(posedge clk); #1;
      for (int i = 0; i < NQ; i++) begin
         if (hs[i]) begin
            x.qid = i; x.cyc = cyc; x.d = srcq[i][0].d;
            xlog.push_back(x);
            void'(srcq[i].pop_front());
         end
      end
      lock = nl; last_sel = nsel; cnt = ncnt; cyc++;
      drive();
      @(negedge clk);
   endtask

   task automatic test_reset();
      rstn = 1'b0; mrdy = 1'b1; gate = '1;
      for (int q = 0; q < NQ; q++) load(q, 2);
      drive();
      for (int c = 0; c < 300 && !(c >= 3 && all_idle()); c++) begin
         if (c == 3) rstn = 1'b1;
         step();
         obs  = {m_tvalid, s_tready, sel_active, sel_qid, frame_count};
         expv = {exp_vld(), exp_rdy(), lock >= 0, QW'(last_sel), cnt};
         n_chk++;
         if (obs !== expv) begin n_fail++; $display("FAIL reset ctl @%0d: got %h want %h", cyc, obs, expv); end
         if (exp_vld()) begin
            n_chk++; obs_d = {m_tdata, m_tkeep, m_tlast}; exp_d = srcq[lock][0];
            if (obs_d !== exp_d) begin n_fail++; $display("FAIL reset data @%0d: got %h want %h", cyc, obs_d, exp_d); end
         end
      end
      n_chk++;
      if (!all_idle()) begin n_fail++; $display("FAIL reset drain: got busy want idle"); end
   endtask

   task automatic test_priority();
      int base = xlog.size();
      int c0 = cyc;
      logic [31:0] cnt0 = cnt;
      gate = '1; mrdy = 1'b1; bubble = '0;
      load(2, 4); load(5, 4); drive();
      for (int c = 0; c < 100 && !all_idle(); c++) begin
         step();
         obs  = {m_tvalid, s_tready, sel_active, sel_qid, frame_count};
         expv = {exp_vld(), exp_rdy(), lock >= 0, QW'(last_sel), cnt};
         n_chk++;
         if (obs !== expv) begin n_fail++; $display("FAIL priority ctl @%0d: got %h want %h", cyc, obs, expv); end
         if (exp_vld()) begin
            n_chk++; obs_d = {m_tdata, m_tkeep, m_tlast}; exp_d = srcq[lock][0];
            if (obs_d !== exp_d) begin n_fail++; $display("FAIL priority data @%0d: got %h want %h", cyc, obs_d, exp_d); end
         end
      end
      n_chk++;
      if (xlog.size() - base != 8) begin
         n_fail++; $display("FAIL priority beats: got %0d want 8", xlog.size() - base);
      end else begin
         for (int k = 0; k < 8; k++) begin
            n_chk++;
            if (xlog[base+k].qid != ((k < 4) ? 5 : 2)) begin
               n_fail++; $display("FAIL priority order beat %0d: got q%0d want q%0d", k, xlog[base+k].qid, (k < 4) ? 5 : 2);
            end
         end
         n_chk++;
         if (xlog[base].cyc != c0 + 1) begin n_fail++; $display("FAIL priority latency: got %0d want 1", xlog[base].cyc - c0); end
         n_chk++;
         if (xlog[base+4].cyc - xlog[base+3].cyc != 2) begin
            n_fail++; $display("FAIL priority gap: got %0d want 2", xlog[base+4].cyc - xlog[base+3].cyc);
         end
      end
      n_chk++;
      if (frame_count !== cnt0 + 32'd2) begin n_fail++; $display("FAIL priority count: got %0d want %0d", frame_count, cnt0 + 2); end
   endtask

   task automatic test_no_preempt();
      int base = xlog.size();
      bit sent7 = 0;
      gate = '1; mrdy = 1'b1; bubble = '0;
      load(1, 6); drive();
      for (int c = 0; c < 100 && !all_idle(); c++) begin
         if (!sent7 && xlog.size() - base == 2) begin load(7, 2); drive(); sent7 = 1; end
         step();
         obs  = {m_tvalid, s_tready, sel_active, sel_qid, frame_count};
         expv = {exp_vld(), exp_rdy(), lock >= 0, QW'(last_sel), cnt};
         n_chk++;
         if (obs !== expv) begin n_fail++; $display("FAIL no_preempt ctl @%0d: got %h want %h", cyc, obs, expv); end
         if (exp_vld()) begin
            n_chk++; obs_d = {m_tdata, m_tkeep, m_tlast}; exp_d = srcq[lock][0];
            if (obs_d !== exp_d) begin n_fail++; $display("FAIL no_preempt data @%0d: got %h want %h", cyc, obs_d, exp_d); end
         end
      end
      n_chk++;
      if (xlog.size() - base != 8) begin
         n_fail++; $display("FAIL no_preempt beats: got %0d want 8", xlog.size() - base);
      end else begin
         for (int k = 0; k < 8; k++) begin
            n_chk++;
            if (xlog[base+k].qid != ((k < 6) ? 1 : 7)) begin
               n_fail++; $display("FAIL no_preempt order beat %0d: got q%0d want q%0d", k, xlog[base+k].qid, (k < 6) ? 1 : 7);
            end
         end
         n_chk++;
         if (xlog[base+6].cyc - xlog[base+5].cyc != 2) begin
            n_fail++; $display("FAIL no_preempt q7 start: got %0d want 2", xlog[base+6].cyc - xlog[base+5].cyc);
         end
      end
   endtask

   task automatic test_gating();
      int base = xlog.size();
      int idle_n = 0;
      bit opened = 0;
      gate = '1; gate[6] = 1'b0; mrdy = 1'b1; bubble = '0;
      load(6, 2); load(0, 4); drive();
      for (int c = 0; c < 100 && !all_idle(); c++) begin
         if (xlog.size() - base >= 1) gate[0] = 1'b0;
         if (!opened && srcq[0].size() == 0 && lock < 0 && ++idle_n == 5) begin
            n_chk++;
            if (srcq[6].size() != 2) begin n_fail++; $display("FAIL gating closed q6: got %0d beats left want 2", srcq[6].size()); end
            gate = '1; opened = 1;
         end
         step();
         obs  = {m_tvalid, s_tready, sel_active, sel_qid, frame_count};
         expv = {exp_vld(), exp_rdy(), lock >= 0, QW'(last_sel), cnt};
         n_chk++;
         if (obs !== expv) begin n_fail++; $display("FAIL gating ctl @%0d: got %h want %h", cyc, obs, expv); end
         if (exp_vld()) begin
            n_chk++; obs_d = {m_tdata, m_tkeep, m_tlast}; exp_d = srcq[lock][0];
            if (obs_d !== exp_d) begin n_fail++; $display("FAIL gating data @%0d: got %h want %h", cyc, obs_d, exp_d); end
         end
      end
      n_chk++;
      if (xlog.size() - base != 6 || xlog[base].qid != 0 || xlog[base+4].qid != 6) begin
         n_fail++; $display("FAIL gating order: got %0d beats first q%0d want 6 beats first q0", xlog.size() - base, xlog[base].qid);
      end
   endtask

   task automatic test_backpressure();
      int base = xlog.size();
      logic [3:0] pat = 4'b1001;
      beat_t sent[$];
      gate = '1; bubble = '0;
      load(3, 8);
      sent = srcq[3];
      drive();
      for (int c = 0; c < 200 && !all_idle(); c++) begin
         mrdy = pat[c % 4];
         bubble[3] = (c == 5 || c == 6);
         drive();
         step();
         obs  = {m_tvalid, s_tready, sel_active, sel_qid, frame_count};
         expv = {exp_vld(), exp_rdy(), lock >= 0, QW'(last_sel), cnt};
         n_chk++;
         if (obs !== expv) begin n_fail++; $display("FAIL backpressure ctl @%0d: got %h want %h", cyc, obs, expv); end
         if (exp_vld()) begin
            n_chk++; obs_d = {m_tdata, m_tkeep, m_tlast}; exp_d = srcq[lock][0];
            if (obs_d !== exp_d) begin n_fail++; $display("FAIL backpressure data @%0d: got %h want %h", cyc, obs_d, exp_d); end
         end
      end
      bubble = '0; mrdy = 1'b1; drive();
      n_chk++;
      if (xlog.size() - base != 8) begin
         n_fail++; $display("FAIL backpressure beats: got %0d want 8", xlog.size() - base);
      end else begin
         for (int k = 0; k < 8; k++) begin
            n_chk++;
            if (xlog[base+k].d !== sent[k].d) begin
               n_fail++; $display("FAIL backpressure order beat %0d: got %h want %h", k, xlog[base+k].d, sent[k].d);
            end
         end
      end
   endtask

   task automatic test_wrap();
      gate = '1; mrdy = 1'b1; bubble = '0; drive();
      force dut.frame_count = 32'hFFFF_FFFF;
      step();
      release dut.frame_count;
      cnt = 32'hFFFF_FFFF;
      load(4, 1); drive();
      for (int c = 0; c < 50 && !(c >= 1 && all_idle()); c++) begin
         step();
         obs  = {m_tvalid, s_tready, sel_active, sel_qid, frame_count};
         expv = {exp_vld(), exp_rdy(), lock >= 0, QW'(last_sel), cnt};
         n_chk++;
         if (obs !== expv) begin n_fail++; $display("FAIL wrap ctl @%0d: got %h want %h", cyc, obs, expv); end
         if (exp_vld()) begin
            n_chk++; obs_d = {m_tdata, m_tkeep, m_tlast}; exp_d = srcq[lock][0];
            if (obs_d !== exp_d) begin n_fail++; $display("FAIL wrap data @%0d: got %h want %h", cyc, obs_d, exp_d); end
         end
      end
      n_chk++;
      if (frame_count !== 32'd0) begin n_fail++; $display("FAIL wrap count: got %h want 00000000", frame_count); end
   endtask

   task automatic test_random();
      int q;
      for (int c = 0; c < 2000 && !(c >= 300 && all_idle()); c++) begin
         if (c < 300) begin
            if ($urandom_range(0, 5) == 0) begin
               q = $urandom_range(0, NQ - 1);
               if (srcq[q].size() < 6) load(q, $urandom_range(1, 5));
            end
            if ($urandom_range(0, 9) == 0) gate = NQ'($urandom);
            mrdy   = ($urandom_range(0, 3) != 0);
            bubble = ($urandom_range(0, 7) == 0) ? NQ'($urandom) : '0;
         end else begin
            gate = '1; mrdy = 1'b1; bubble = '0;
         end
         drive();
         step();
         obs  = {m_tvalid, s_tready, sel_active, sel_qid, frame_count};
         expv = {exp_vld(), exp_rdy(), lock >= 0, QW'(last_sel), cnt};
         n_chk++;
         if (obs !== expv) begin n_fail++; $display("FAIL random ctl @%0d: got %h want %h", cyc, obs, expv); end
         if (exp_vld()) begin
            n_chk++; obs_d = {m_tdata, m_tkeep, m_tlast}; exp_d = srcq[lock][0];
            if (obs_d !== exp_d) begin n_fail++; $display("FAIL random data @%0d: got %h want %h", cyc, obs_d, exp_d); end
         end
      end
      n_chk++;
      if (!all_idle()) begin n_fail++; $display("FAIL random drain: got busy want idle"); end
   endtask

   initial begin
      rstn = 1'b0; mrdy = 1'b0; gate = '1; bubble = '0;
      lock = -1; last_sel = 0; cnt = '0; cyc = 0; n_chk = 0; n_fail = 0;
      drive();
      test_reset();
      test_priority();
      test_no_preempt();
      test_gating();
      test_backpressure();
      test_wrap();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
